// File: rtl/udiv_pkg.sv
// rtl/udiv_pkg.sv - shared FSM encoding and constants for the sequential unsigned divider
package udiv_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int UDIV_MAX_WIDTH = 64;

    // Quotient reported on divide-by-zero; instances slice the low WIDTH bits.
    localparam logic [UDIV_MAX_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/udiv_step.sv
// rtl/udiv_step.sv - one combinational restoring-division step
module udiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   r_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_out,
    output logic             qbit
);

    // The partial remainder always stays below the divisor, so r_in[WIDTH] is zero.
    // Carrying it into a WIDTH+2 trial keeps the step exact without an assumption.
    logic [WIDTH+1:0] trial;
    logic [WIDTH+1:0] d_ext;

    assign trial = {r_in, bit_in};
    assign d_ext = {2'b00, d};

    always_comb begin
        qbit  = (trial >= d_ext);
        r_out = trial[WIDTH:0];
        if (qbit) begin
            r_out = (WIDTH+1)'(trial - d_ext);
        end
    end

endmodule

// File: rtl/udivider_seq.sv
// rtl/udivider_seq.sv - sequential restoring unsigned divider, one quotient bit per clock
module udivider_seq
    import udiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    state_t           state;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH:0]   r_reg;
    logic [WIDTH:0]   r_next;
    logic             qbit;
    logic [WIDTH-1:0] q_next;
    logic [CNT_W-1:0] cnt;

    udiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r_in   (r_reg),
        .bit_in (q_reg[WIDTH-1]),
        .d      (d_reg),
        .r_out  (r_next),
        .qbit   (qbit)
    );

    assign q_next = {q_reg[WIDTH-2:0], qbit};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            q_reg     <= '0;
            d_reg     <= '0;
            r_reg     <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        d_reg    <= divisor;
                        q_reg    <= dividend;
                        r_reg    <= '0;
                        cnt      <= '0;
                        done     <= 1'b0;
                        div_zero <= 1'b0;
                        if (divisor == '0) begin
                            // Divide-by-zero short-circuits the iteration entirely.
                            state     <= S_DONE;
                            done      <= 1'b1;
                            div_zero  <= 1'b1;
                            quotient  <= DIV_ZERO_QUOT[WIDTH-1:0];
                            remainder <= dividend;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next[WIDTH-1:0];
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udivider_seq.sv
// tb/tb_udivider_seq.sv - directed and model-checked bench for udivider_seq
module tb_udivider_seq;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    int n_vec  = 0;
    int n_miss = 0;

    udivider_seq #(
        .WIDTH (WIDTH),
        .CNT_W (6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    // lat counts rising edges from the accept edge (inclusive) until done is visible.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int poke_at);
        logic [31:0] exp_q, exp_r;
        logic        exp_dz;
        int          exp_lat, exp_busy, lat, busy_cnt;
        if (b == 32'd0) begin
            exp_q = 32'hFFFF_FFFF; exp_r = a; exp_dz = 1'b1; exp_lat = 1; exp_busy = 0;
        end else begin
            exp_q = a / b; exp_r = a % b; exp_dz = 1'b0; exp_lat = WIDTH + 1; exp_busy = WIDTH;
        end
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = ~a;
        divisor  = b ^ 32'h5A5A_0001;
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < 200) begin
            if (busy) busy_cnt++;
            start = (lat - 1 == poke_at);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk({tag, " done"},     64'(done),      64'd1);
        chk({tag, " lat"},      64'(lat),       64'(exp_lat));
        chk({tag, " busycyc"},  64'(busy_cnt),  64'(exp_busy));
        chk({tag, " busy_off"}, 64'(busy),      64'd0);
        chk({tag, " quot"},     64'(quotient),  64'(exp_q));
        chk({tag, " rem"},      64'(remainder), 64'(exp_r));
        chk({tag, " dz"},       64'(div_zero),  64'(exp_dz));
    endtask

    initial begin
        int          quiet_done;
        logic [31:0] ra, rb;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk("rst busy", 64'(busy),      64'd0);
        chk("rst done", 64'(done),      64'd0);
        chk("rst dz",   64'(div_zero),  64'd0);
        chk("rst quot", 64'(quotient),  64'd0);
        chk("rst rem",  64'(remainder), 64'd0);

        // Reset has priority over a coincident start.
        dividend = 32'd50; divisor = 32'd5; start = 1'b1;
        @(negedge clk);
        chk("rst_vs_start busy", 64'(busy), 64'd0);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        run_op("100/7", 32'd100, 32'd7, -1);
        repeat (3) @(negedge clk);
        chk("hold quot", 64'(quotient),  64'd14);
        chk("hold rem",  64'(remainder), 64'd2);
        chk("hold done", 64'(done),      64'd1);

        run_op("ffffffff/1", 32'hFFFF_FFFF, 32'd1, -1);
        run_op("5/ffffffff", 32'd5, 32'hFFFF_FFFF, -1);
        run_op("1234/0", 32'd1234, 32'd0, -1);

        // A start pulse in the 10th RUN cycle must be ignored.
        run_op("1000/9 poke", 32'd1000, 32'd9, 10);

        // Abort with reset in the middle of an operation.
        dividend = 32'h0000_DEAD; divisor = 32'h17; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", 64'(busy),      64'd0);
        chk("abort done", 64'(done),      64'd0);
        chk("abort quot", 64'(quotient),  64'd0);
        chk("abort rem",  64'(remainder), 64'd0);
        quiet_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) quiet_done++;
        end
        chk("abort quiet", 64'(quiet_done), 64'd0);
        run_op("9/3", 32'd9, 32'd3, -1);

        // Back-to-back: start stays high through DONE, second op accepted with no IDLE gap.
        dividend = 32'd17; divisor = 32'd5; start = 1'b1;
        @(negedge clk);
        quiet_done = 1;
        while (!done && quiet_done < 200) begin
            @(negedge clk);
            quiet_done++;
        end
        chk("b2b1 lat",  64'(quiet_done), 64'(WIDTH + 1));
        chk("b2b1 quot", 64'(quotient),   64'd3);
        chk("b2b1 rem",  64'(remainder),  64'd2);
        dividend = 32'h8000_0000; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        chk("b2b2 done_fall", 64'(done), 64'd0);
        chk("b2b2 busy_rise", 64'(busy), 64'd1);
        quiet_done = 1;
        while (!done && quiet_done < 200) begin
            @(negedge clk);
            quiet_done++;
        end
        chk("b2b2 lat",  64'(quiet_done), 64'(WIDTH + 1));
        chk("b2b2 quot", 64'(quotient),   64'h2AAA_AAAA);
        chk("b2b2 rem",  64'(remainder),  64'd2);

        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (i % 37 == 0) rb = 32'd0;
            run_op("rand", ra, rb, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
